fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch pipeline stage, directly upstream of the decode stage.
- Owns the PC and issues one-outstanding requests to instruction memory over a req/ready handshake.
- Registers the fetched instruction and its PC into the decode inputs.
- Accepts branch redirects from decode, honours the downstream stall, and inserts NOP bubbles when no valid instruction is available.

Parameters:
ADDRESS_SIZE, 32, width of PC, addresses and instruction words
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
F_imem_req  output  1  memory request valid
F_imem_addr  output  ADDRESS_SIZE  request address, held stable while req=1 and ready=0
F_imem_ready  input  1  response valid; a transfer completes when req and ready are both 1
F_imem_data  input  ADDRESS_SIZE  instruction word, valid when ready=1
F_branch  input  1  redirect request from decode
F_branch_target  input  ADDRESS_SIZE  redirect PC
F_stall_in  input  1  downstream stall
F_instruction  output  ADDRESS_SIZE  instruction to decode
F_pc  output  ADDRESS_SIZE  PC of F_instruction
F_valid  output  1  F_instruction is a real fetched instruction
F_stall  output  1  stall to the upstream chain; equals F_stall_in (combinational)

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Registers: pc, req_addr (drives F_imem_addr), state, hold_instr, hold_pc, F_instruction, F_pc, F_valid.
- Reset values:
  - pc = req_addr = RESET_PC; state = FETCH.
  - F_instruction = NOP_INSTR; F_pc = 0; F_valid = 0; hold_instr = NOP_INSTR; hold_pc = 0.
  - F_imem_req is forced 0 while reset=1.
- Request output: F_imem_req = 1 in FETCH and DRAIN, 0 in HOLD.
- pc always holds the address of the next instruction to be requested.
- "Bubble" means: F_instruction <= NOP_INSTR, F_valid <= 0, F_pc unchanged.
- Branch is honoured only when F_stall_in = 0. In that case the instruction in decode is consumed and the next thing presented to decode is a bubble.
- Branch takes priority over a same-cycle response.
- State FETCH:
  - branch & !stall: pc <= target; bubble. If ready=1 this cycle, discard data, req_addr <= target, stay FETCH. Else go to DRAIN.
  - ready & !stall: F_instruction <= data; F_pc <= req_addr; F_valid <= 1; pc <= req_addr_plus_4 = req_addr+4; req_addr <= req_addr+4; stay FETCH. Zero-wait memory gives 1 instruction/cycle.
  - ready & stall: hold_instr <= data; hold_pc <= req_addr; pc <= req_addr <= req_addr+4; go to HOLD. Decode outputs stay frozen.
  - !ready & !stall: bubble.
  - !ready & stall: outputs frozen.
- State HOLD (response buffered, no request):
  - stall: remain; all outputs frozen.
  - !stall & branch: discard hold; bubble; pc <= req_addr <= target; go to FETCH.
  - !stall & !branch: F_instruction <= hold_instr; F_pc <= hold_pc; F_valid <= 1; go to FETCH.
- State DRAIN (stale request in flight):
  - F_imem_req = 1 with the old req_addr until ready.
  - On ready: data discarded; req_addr <= pc; go to FETCH.
  - F_branch is ignored, since decode holds a bubble.
  - Outputs: bubble when !stall, frozen when stall.
- Arithmetic: PC increment is +4 modulo 2^ADDRESS_SIZE; 32'hFFFF_FFFC wraps to 0.
- Reset mid-operation: a pending request is abandoned. Any late F_imem_ready after reset is treated as the response to the first post-reset request, so the memory must itself be reset with the core.
- Latency: a response accepted in cycle N is visible on F_instruction in cycle N+1 if not stalled.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output F_perf_bubbles (ADDRESS_SIZE wide). It resets to 0 and increments (wrapping) on every cycle in which a bubble is written to the decode outputs.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ready tied 1 -> F_imem_addr 0,4,8,... on consecutive cycles; F_pc 0,4,8 one cycle later; F_valid=1 from 2nd post-reset cycle.
- Ready asserted every 3rd cycle, data 32'hA0, 32'hA1 -> each word appears once with correct F_pc, two bubbles (NOP, F_valid=0) between; F_imem_addr stable while waiting.
- Response 32'hB0 at addr 8 arrives with F_stall_in=1 for 4 cycles -> F_imem_req=0, outputs frozen; on release F_instruction=32'hB0, F_pc=8, then request addr 12.
- F_branch=1, target 32'h100 while a request to 16 is pending -> DRAIN; stale response discarded; next F_imem_addr=32'h100; decode sees only bubbles until the 32'h100 word.
- Branch and ready in the same cycle, target 32'h40 -> data dropped; F_imem_addr=32'h40 next cycle; one bubble.
- FETCH_PERF_EN defined, ready every 2nd cycle for 10 cycles -> F_perf_bubbles=5; reset mid-run -> counter 0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests, feeds decode.
// Optional macro FETCH_PERF_EN adds the F_perf_bubbles counter output.
module fetch_stage #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [ADDRESS_SIZE-1:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    F_imem_req,
    output logic [ADDRESS_SIZE-1:0] F_imem_addr,
    input  logic                    F_imem_ready,
    input  logic [ADDRESS_SIZE-1:0] F_imem_data,
    input  logic                    F_branch,
    input  logic [ADDRESS_SIZE-1:0] F_branch_target,
    input  logic                    F_stall_in,
    output logic [ADDRESS_SIZE-1:0] F_instruction,
    output logic [ADDRESS_SIZE-1:0] F_pc,
    output logic                    F_valid,
    output logic                    F_stall
`ifdef FETCH_PERF_EN
    ,
    output logic [ADDRESS_SIZE-1:0] F_perf_bubbles
`endif
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]              state_reg, state_next;
    logic [ADDRESS_SIZE-1:0] pc_reg, pc_next;
    logic [ADDRESS_SIZE-1:0] req_addr_reg, req_addr_next;
    logic [ADDRESS_SIZE-1:0] hold_instr_reg, hold_instr_next;
    logic [ADDRESS_SIZE-1:0] hold_pc_reg, hold_pc_next;
    logic [ADDRESS_SIZE-1:0] instr_next, fpc_next;
    logic                    valid_next;
    logic                    bubble;
    logic [ADDRESS_SIZE-1:0] req_addr_plus_4;

    assign req_addr_plus_4 = req_addr_reg + {{(ADDRESS_SIZE-3){1'b0}}, 3'd4};
    assign F_imem_req      = !reset && (state_reg != HOLD);
    assign F_imem_addr     = req_addr_reg;
    assign F_stall         = F_stall_in;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_addr_next   = req_addr_reg;
        hold_instr_next = hold_instr_reg;
        hold_pc_next    = hold_pc_reg;
        instr_next      = F_instruction;
        fpc_next        = F_pc;
        valid_next      = F_valid;
        bubble          = 1'b0;
        case (state_reg)
            FETCH: begin
                if (F_branch && !F_stall_in) begin
                    // Redirect wins over a same-cycle response; an unanswered request must drain first.
                    pc_next = F_branch_target;
                    bubble  = 1'b1;
                    if (F_imem_ready) req_addr_next = F_branch_target;
                    else              state_next    = DRAIN;
                end else if (F_imem_ready) begin
                    pc_next       = req_addr_plus_4;
                    req_addr_next = req_addr_plus_4;
                    if (!F_stall_in) begin
                        instr_next = F_imem_data;
                        fpc_next   = req_addr_reg;
                        valid_next = 1'b1;
                    end else begin
                        hold_instr_next = F_imem_data;
                        hold_pc_next    = req_addr_reg;
                        state_next      = HOLD;
                    end
                end else if (!F_stall_in) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (!F_stall_in) begin
                    state_next = FETCH;
                    if (F_branch) begin
                        bubble        = 1'b1;
                        pc_next       = F_branch_target;
                        req_addr_next = F_branch_target;
                    end else begin
                        instr_next = hold_instr_reg;
                        fpc_next   = hold_pc_reg;
                        valid_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Decode already holds a bubble here, so redirects are not expected.
                if (F_imem_ready) begin
                    req_addr_next = pc_reg;
                    state_next    = FETCH;
                end
                if (!F_stall_in) bubble = 1'b1;
            end
            default: state_next = FETCH;
        endcase
        if (bubble) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            req_addr_reg   <= RESET_PC;
            hold_instr_reg <= NOP_INSTR;
            hold_pc_reg    <= '0;
            F_instruction  <= NOP_INSTR;
            F_pc           <= '0;
            F_valid        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_addr_reg   <= req_addr_next;
            hold_instr_reg <= hold_instr_next;
            hold_pc_reg    <= hold_pc_next;
            F_instruction  <= instr_next;
            F_pc           <= fpc_next;
            F_valid        <= valid_next;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)       F_perf_bubbles <= '0;
        else if (bubble) F_perf_bubbles <= F_perf_bubbles + {{(ADDRESS_SIZE-1){1'b0}}, 1'b1};
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; perf-counter checks compile in with FETCH_PERF_EN.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_imem_req;
    logic [31:0] F_imem_addr;
    logic        F_imem_ready;
    logic [31:0] F_imem_data;
    logic        F_branch;
    logic [31:0] F_branch_target;
    logic        F_stall_in;
    logic [31:0] F_instruction;
    logic [31:0] F_pc;
    logic        F_valid;
    logic        F_stall;
`ifdef FETCH_PERF_EN
    logic [31:0] F_perf_bubbles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .F_imem_req     (F_imem_req),
        .F_imem_addr    (F_imem_addr),
        .F_imem_ready   (F_imem_ready),
        .F_imem_data    (F_imem_data),
        .F_branch       (F_branch),
        .F_branch_target(F_branch_target),
        .F_stall_in     (F_stall_in),
        .F_instruction  (F_instruction),
        .F_pc           (F_pc),
        .F_valid        (F_valid),
        .F_stall        (F_stall)
`ifdef FETCH_PERF_EN
        ,
        .F_perf_bubbles (F_perf_bubbles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, confirm the stall pass-through, then clock it in.
    task automatic cyc(input logic rdy, input logic [31:0] data, input logic br,
                       input logic [31:0] tgt, input logic st);
        F_imem_ready    = rdy;
        F_imem_data     = data;
        F_branch        = br;
        F_branch_target = tgt;
        F_stall_in      = st;
        #1;
        chk("stall_pass", {31'b0, F_stall}, {31'b0, st});
        tick();
    endtask

    task automatic expo(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic valid);
        chk({tag, "_instr"}, F_instruction, instr);
        chk({tag, "_pc"}, F_pc, pc);
        chk({tag, "_valid"}, {31'b0, F_valid}, {31'b0, valid});
    endtask

    task automatic reset_dut();
        reset           = 1'b1;
        F_imem_ready    = 1'b0;
        F_imem_data     = '0;
        F_branch        = 1'b0;
        F_branch_target = '0;
        F_stall_in      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        F_imem_ready    = 1'b0;
        F_imem_data     = '0;
        F_branch        = 1'b0;
        F_branch_target = '0;
        F_stall_in      = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'b0, F_imem_req}, 32'd0);
        chk("rst_addr", F_imem_addr, 32'd0);
        expo("rst", NOP, 32'd0, 1'b0);

        // Zero-wait memory: one instruction per cycle
        reset = 1'b0;
        #1;
        chk("t1_req", {31'b0, F_imem_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", F_imem_addr, 32'(4 * i));
            cyc(1'b1, 32'hD000_0000 + 32'(4 * i), 1'b0, 32'd0, 1'b0);
            expo("t1", 32'hD000_0000 + 32'(4 * i), 32'(4 * i), 1'b1);
        end
        chk("t1_addr_end", F_imem_addr, 32'd16);

        // Response every third cycle
        reset_dut();
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);      expo("t2_c0", NOP, 32'd0, 1'b0); chk("t2_a0", F_imem_addr, 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);      expo("t2_c1", NOP, 32'd0, 1'b0); chk("t2_a1", F_imem_addr, 32'd0);
        cyc(1'b1, 32'hA0, 1'b0, 32'd0, 1'b0);     expo("t2_c2", 32'hA0, 32'd0, 1'b1); chk("t2_a2", F_imem_addr, 32'd4);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);      expo("t2_c3", NOP, 32'd0, 1'b0); chk("t2_a3", F_imem_addr, 32'd4);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);      expo("t2_c4", NOP, 32'd0, 1'b0); chk("t2_a4", F_imem_addr, 32'd4);
        cyc(1'b1, 32'hA1, 1'b0, 32'd0, 1'b0);     expo("t2_c5", 32'hA1, 32'd4, 1'b1); chk("t2_a5", F_imem_addr, 32'd8);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);      expo("t2_c6", NOP, 32'd4, 1'b0); chk("t2_a6", F_imem_addr, 32'd8);

        // Response under stall is buffered; branch during stall ignored
        cyc(1'b1, 32'hB0, 1'b0, 32'd0, 1'b1);
        expo("t3_s0", NOP, 32'd4, 1'b0);
        chk("t3_req_s0", {31'b0, F_imem_req}, 32'd0);
        chk("t3_addr_s0", F_imem_addr, 32'd12);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 32'h300, 1'b1);
            expo("t3_s", NOP, 32'd4, 1'b0);
            chk("t3_req_s", {31'b0, F_imem_req}, 32'd0);
        end
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        expo("t3_rel", 32'hB0, 32'd8, 1'b1);
        chk("t3_req_rel", {31'b0, F_imem_req}, 32'd1);
        chk("t3_addr_rel", F_imem_addr, 32'd12);

        // Branch with a request pending -> drain the stale response
        cyc(1'b1, 32'hC0, 1'b0, 32'd0, 1'b0);      expo("t4_c0", 32'hC0, 32'd12, 1'b1); chk("t4_a0", F_imem_addr, 32'd16);
        cyc(1'b0, 32'd0, 1'b1, 32'h100, 1'b0);     expo("t4_br", NOP, 32'd12, 1'b0);
        chk("t4_req_dr", {31'b0, F_imem_req}, 32'd1);
        chk("t4_a_dr", F_imem_addr, 32'd16);
        cyc(1'b0, 32'd0, 1'b1, 32'h200, 1'b0);     expo("t4_dr2", NOP, 32'd12, 1'b0); chk("t4_a_dr2", F_imem_addr, 32'd16);
        cyc(1'b1, 32'hDEAD, 1'b0, 32'd0, 1'b0);    expo("t4_stale", NOP, 32'd12, 1'b0); chk("t4_a_tgt", F_imem_addr, 32'h100);
        cyc(1'b1, 32'hE0, 1'b0, 32'd0, 1'b0);      expo("t4_tgt", 32'hE0, 32'h100, 1'b1); chk("t4_a_next", F_imem_addr, 32'h104);

        // Branch and response in the same cycle
        cyc(1'b1, 32'hBAD, 1'b1, 32'h40, 1'b0);    expo("t5_br", NOP, 32'h100, 1'b0); chk("t5_a", F_imem_addr, 32'h40);
        cyc(1'b1, 32'hF0, 1'b0, 32'd0, 1'b0);      expo("t5_tgt", 32'hF0, 32'h40, 1'b1); chk("t5_a2", F_imem_addr, 32'h44);

        // Branch out of HOLD discards the buffered word
        cyc(1'b1, 32'h11, 1'b0, 32'd0, 1'b1);      expo("t6_hold", 32'hF0, 32'h40, 1'b1);
        chk("t6_req", {31'b0, F_imem_req}, 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 32'h80, 1'b0);      expo("t6_br", NOP, 32'h40, 1'b0); chk("t6_a", F_imem_addr, 32'h80);
        cyc(1'b1, 32'h22, 1'b0, 32'd0, 1'b0);      expo("t6_tgt", 32'h22, 32'h80, 1'b1); chk("t6_a2", F_imem_addr, 32'h84);

        // PC wrap at the top of the address space
        cyc(1'b1, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0); expo("t7_br", NOP, 32'h80, 1'b0); chk("t7_a", F_imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 32'h33, 1'b0, 32'd0, 1'b0);      expo("t7_top", 32'h33, 32'hFFFF_FFFC, 1'b1); chk("t7_wrap", F_imem_addr, 32'd0);

        // Stall without response freezes a valid instruction; drain finishing under stall
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);       expo("t8_frz", 32'h33, 32'hFFFF_FFFC, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 32'h50, 1'b0);      expo("t8_br", NOP, 32'hFFFF_FFFC, 1'b0); chk("t8_a", F_imem_addr, 32'd0);
        cyc(1'b1, 32'h77, 1'b0, 32'd0, 1'b1);      expo("t8_dr", NOP, 32'hFFFF_FFFC, 1'b0); chk("t8_a2", F_imem_addr, 32'h50);

        // Reset mid-operation
        reset = 1'b1;
        F_imem_ready = 1'b0;
        #1;
        chk("t9_req_rst", {31'b0, F_imem_req}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("t9_addr", F_imem_addr, 32'd0);
        expo("t9", NOP, 32'd0, 1'b0);

`ifdef FETCH_PERF_EN
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            cyc((i % 2) == 1, 32'h55, 1'b0, 32'd0, 1'b0);
        end
        chk("perf_cnt", F_perf_bubbles, 32'd5);
        reset = 1'b1;
        tick();
        chk("perf_rst", F_perf_bubbles, 32'd0);
        chk("perf_rst_addr", F_imem_addr, 32'd0);
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
